// File: rtl/read_buffer_fifo_pkg.sv
// Shared sizing for the read buffer, read controller and scratchpad.
// Holds the word/depth defaults and the derived pointer/count widths.
package read_buffer_fifo_pkg;

  localparam int RBF_DATA_WIDTH = 16;
  localparam int RBF_DEPTH      = 8;
  localparam int RBF_ADDR_WIDTH = $clog2(RBF_DEPTH);
  localparam int RBF_CNT_WIDTH  = RBF_ADDR_WIDTH + 1;

  // Count must reach DEPTH itself, hence one bit more than a pointer.
  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/read_buffer_fifo_buffer_mem.sv
// Storage array: synchronous write, asynchronous read, DEPTH x DATA_WIDTH.
// Ports: clk, we, waddr, wdata (write side); raddr, rdata (read side).
module buffer_mem
  import read_buffer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = RBF_DATA_WIDTH,
  parameter int DEPTH      = RBF_DEPTH,
  parameter int ADDR_WIDTH = RBF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/read_buffer_fifo.sv
// Circular read buffer feeding the scratchpad read controller.
// Ports: clk, rst; wr_en/wr_data push side with full; read_req_buffer
// pull side answered by a one-cycle valid with rd_data; empty, count,
// sticky overflow.
module read_buffer_fifo
  import read_buffer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = RBF_DATA_WIDTH,
  parameter int DEPTH      = RBF_DEPTH,
  parameter int ADDR_WIDTH = RBF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  read_req_buffer,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam int CW = cnt_width(ADDR_WIDTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  push;
  logic                  pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign push = wr_en & ~full;
  // ~valid: the controller is still requesting while it sees the
  // pulse, so a second pop in that cycle would be a stray read.
  assign pop  = read_req_buffer & ~empty & ~valid;

  buffer_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (push & ~rst),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .raddr(rd_ptr),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      valid    <= 1'b0;
      rd_data  <= '0;
      overflow <= 1'b0;
    end else begin
      valid <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem_rdata;
      end
      if (wr_en & full) begin
        overflow <= 1'b1;
      end
      unique case (1'b1)
        push & ~pop: count <= count + 1'b1;
        pop & ~push: count <= count - 1'b1;
        default:     ;
      endcase
    end
  end

endmodule

// File: tb/tb_read_buffer_fifo.sv
// Self-checking bench for read_buffer_fifo: vector table, directed
// corner sequences and random traffic against a queue-based model.
module tb_read_buffer_fifo;
  import read_buffer_fifo_pkg::*;

  localparam int DW = 16;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          read_req_buffer;
  logic          valid;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;

  read_buffer_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (D),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .full           (full),
    .read_req_buffer(read_req_buffer),
    .valid          (valid),
    .rd_data        (rd_data),
    .empty          (empty),
    .count          (count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] q[$];
  bit            m_valid;
  logic [DW-1:0] m_rd;
  bit            m_ovf;
  logic [DW-1:0] got[$];

  typedef struct {
    bit            r;
    bit            we;
    logic [DW-1:0] wd;
    bit            req;
    bit            ev;
    logic [DW-1:0] erd;
    int            ecnt;
    bit            eovf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit we, input logic [DW-1:0] wd,
                       input bit req);
    rst             = r;
    wr_en           = we;
    wr_data         = wd;
    read_req_buffer = req;
  endtask

  // One clock: advance the model with the applied inputs, then compare.
  task automatic step();
    bit m_full;
    bit m_empty;
    bit pop;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_valid = 1'b0;
      m_rd    = '0;
      m_ovf   = 1'b0;
    end else begin
      m_full  = (q.size() == D);
      m_empty = (q.size() == 0);
      pop     = read_req_buffer && !m_empty && !m_valid;
      if (pop) m_rd = q.pop_front();
      m_valid = pop;
      if (wr_en && !m_full) q.push_back(wr_data);
      if (wr_en && m_full) m_ovf = 1'b1;
    end
    #1;
    chk("m_count", 32'(count), 32'(q.size()));
    chk("m_empty", 32'(empty), 32'(q.size() == 0));
    chk("m_full", 32'(full), 32'(q.size() == D));
    chk("m_valid", 32'(valid), 32'(m_valid));
    chk("m_rd_data", 32'(rd_data), 32'(m_rd));
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
    if (valid) got.push_back(rd_data);
  endtask

  // Behaves like the read controller: request until valid, drop one cycle.
  task automatic drain(input int n);
    int k = 0;
    while (got.size() < n && k < 200) begin
      drive(0, 0, '0, !valid);
      step();
      k++;
    end
    chk("drain_done", 32'(got.size()), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int bb;
    bit pv;
    int idx;
    int k;
    bit we;

    drive(1, 0, '0, 0);

    tbl.push_back('{1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0});
    tbl.push_back('{0, 1, 16'h0011, 0, 0, 16'h0000, 1, 0});
    tbl.push_back('{0, 1, 16'h0022, 0, 0, 16'h0000, 2, 0});
    tbl.push_back('{0, 1, 16'h0033, 0, 0, 16'h0000, 3, 0});
    tbl.push_back('{0, 0, 16'h0000, 1, 1, 16'h0011, 2, 0});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 16'h0011, 2, 0});
    tbl.push_back('{0, 0, 16'h0000, 1, 1, 16'h0022, 1, 0});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 16'h0022, 1, 0});
    tbl.push_back('{0, 0, 16'h0000, 1, 1, 16'h0033, 0, 0});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 16'h0033, 0, 0});

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].we, tbl[i].wd, tbl[i].req);
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_rd", i), 32'(rd_data), 32'(tbl[i].erd));
      chk($sformatf("tbl%0d_cnt", i), 32'(count), 32'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].eovf));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].ecnt == 0));
      chk($sformatf("tbl%0d_full", i), 32'(full), 32'(0));
    end

    // Continuous request with two entries queued.
    drive(0, 1, 16'h0A01, 0); step();
    drive(0, 1, 16'h0A02, 0); step();
    got.delete();
    bb = 0;
    pv = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, '0, 1);
      step();
      if (valid && pv) bb++;
      pv = valid;
    end
    chk("b2b_gap", 32'(bb), 32'(0));
    chk("b2b_n", 32'(got.size()), 32'(2));
    if (got.size() == 2) begin
      chk("b2b_w0", 32'(got[0]), 32'(16'h0A01));
      chk("b2b_w1", 32'(got[1]), 32'(16'h0A02));
    end

    // Fill, overflow, push+pop while full, drain.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 16'(16'h0100 + i), 0);
      step();
    end
    drive(0, 1, 16'hDEAD, 0); step();
    chk("full_flag", 32'(full), 32'(1));
    chk("full_cnt", 32'(count), 32'(8));
    chk("full_ovf", 32'(overflow), 32'(1));
    got.delete();
    drive(0, 1, 16'hBEEF, 1); step();
    chk("full_pp_cnt", 32'(count), 32'(7));
    drain(8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("drain_w%0d", i), 32'(got[i]), 32'(16'h0100 + i));
    chk("drain_empty", 32'(empty), 32'(1));

    // Reset right after a pop is accepted.
    drive(0, 1, 16'h0077, 0); step();
    drive(0, 1, 16'h0088, 0); step();
    drive(0, 0, '0, 1); step();
    chk("rst_pre_valid", 32'(valid), 32'(1));
    drive(1, 0, '0, 1); step();
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_cnt", 32'(count), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_ovf", 32'(overflow), 32'(0));
    // Reset in the same edge as an accepted pop.
    drive(0, 1, 16'h0099, 0); step();
    drive(1, 0, '0, 1); step();
    chk("rst_pop_valid", 32'(valid), 32'(0));
    chk("rst_pop_rd", 32'(rd_data), 32'(0));
    drive(0, 1, 16'h0042, 0); step();
    got.delete();
    drain(1);
    if (got.size() == 1) chk("post_rst_w", 32'(got[0]), 32'(16'h0042));

    // Wrap-around: 20 indexed words through random push/pop mix.
    got.delete();
    idx = 0;
    k = 0;
    while (got.size() < 20 && k < 1000) begin
      we = (idx < 20) && (q.size() < D) && ($urandom_range(0, 1) == 1);
      drive(0, we, 16'(idx), $urandom_range(0, 1) == 1);
      step();
      if (we) idx++;
      k++;
    end
    chk("wrap_n", 32'(got.size()), 32'(20));
    for (int i = 0; i < 20 && i < got.size(); i++)
      chk($sformatf("wrap_w%0d", i), 32'(got[i]), 32'(i));

    // Random traffic with occasional reset, checked by the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0,
            16'($urandom), $urandom_range(0, 1) == 1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/read_buffer_fifo.md
Name: read_buffer_fifo

Overview:
- Circular FIFO buffer directly upstream of the scratchpad read controller.
- A producer (memory or input interface) pushes words on the write side.
- The read controller pulls words using a read_req/valid handshake: it holds read_req high until it sees a one-cycle valid pulse carrying the data, then writes that data into the scratchpad.
- Provides occupancy, full/empty flags and a sticky overflow error.

Parameters:
DATA_WIDTH, 16, width of each stored word
DEPTH, 8, number of entries; must be a power of two, at least 2
ADDR_WIDTH, 3, log2(DEPTH); pointer width

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
wr_en  input  1  push request from producer
wr_data  input  DATA_WIDTH  word to push
full  output  1  count == DEPTH (combinational from count)
read_req_buffer  input  1  pull request from the read controller, level-held
valid  output  1  one-cycle pulse: rd_data holds the popped word
rd_data  output  DATA_WIDTH  registered popped word
empty  output  1  count == 0 (combinational from count)
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: set when a push is attempted while full

Behaviour:
- Reset: sampled on clk rising edge when rst=1. It clears wr_ptr, rd_ptr, count, valid, rd_data and overflow to 0. Memory contents are not cleared.
- Reset has priority over every other event, including mid-handshake: a pending valid is cancelled and the popped word is lost.
- Pop accept condition: pop = read_req_buffer & ~empty & ~valid.
  - The ~valid term blocks a second pop in the cycle valid is high, when the controller is still in its request state.
- On a pop:
  - rd_data <= mem[rd_ptr];
  - rd_ptr <= rd_ptr + 1, wrapping modulo DEPTH;
  - valid <= 1 on the next edge.
- valid is high for exactly one cycle; it returns to 0 on the following edge.
- Latency: read_req_buffer asserted with the FIFO non-empty gives valid one cycle later.
- If the FIFO is empty, the request stays pending with no pop. valid rises one cycle after the first cycle in which a word is present in the FIFO.
- Push accept condition: push = wr_en & ~full.
  - On a push: mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr + 1, wrapping modulo DEPTH.
- A push while full is dropped, and overflow <= 1. overflow stays set until rst.
- count update: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
- Simultaneous push and pop when empty (count=0): pop is not accepted. The pushed word becomes available the next cycle.
- Simultaneous push and pop when full: the push is rejected (full is evaluated before the pop) and overflow is set.
- Pointer wrap: the pointers are ADDR_WIDTH bits wide and wrap naturally. full/empty are derived only from count, never from pointer comparison.
- rd_data holds its last value between pops.
- No read-before-write hazard: because count gating forbids popping an empty slot, the same entry is never written and read in one cycle.

Decomposition:
- Shared package: DATA_WIDTH and DEPTH defaults, ADDR_WIDTH derivation, and a constant for the count width (ADDR_WIDTH+1). These are shared with the read controller and the scratchpad.
- One natural sub-module: buffer_mem.
  - Synchronous-write, asynchronous-read register array, DEPTH x DATA_WIDTH.
  - Ports: clk, we, waddr, wdata, raddr, rdata.
- Pointer, count, flag and handshake logic stay in read_buffer_fifo.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, valid=0, overflow=0. read_req_buffer held high for 5 cycles on the empty FIFO gives valid=0 throughout.
- Push 0x0011, 0x0022, 0x0033 on three consecutive cycles; then hold read_req_buffer high until valid, drop it one cycle, and repeat -> valid pulses carry 0x0011, 0x0022, 0x0033 in order, each exactly one cycle wide. count ends at 0.
- Hold read_req_buffer high continuously with 2 entries queued -> valid pulses are never back-to-back: there is at least one non-valid cycle between them, and no entry is skipped or duplicated.
- Push 8 words (0x0100..0x0107), then push 0xDEAD -> full=1, count=8, overflow=1. Draining returns 0x0100..0x0107; 0xDEAD never appears.
- Wrap-around: 20 interleaved push/pop operations with data equal to the index (0..19) -> output sequence 0..19 with no loss. count matches a reference model every cycle.
- Assert rst one cycle after a pop is accepted -> valid=0 on the next edge, count=0, empty=1, overflow cleared. A subsequent push and pop of 0x0042 returns 0x0042.
